// File: rtl/ps2_mouse_packetizer_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package ps2_pkg;

    typedef enum logic [0:0] {
        RX_IDLE  = 1'b0,
        RX_SHIFT = 1'b1
    } rx_state_t;

    typedef enum logic [1:0] {
        ASM_B0 = 2'd0,
        ASM_B1 = 2'd1,
        ASM_B2 = 2'd2
    } asm_state_t;

    localparam int ST_L       = 0;
    localparam int ST_R       = 1;
    localparam int ST_M       = 2;
    localparam int ST_ALWAYS1 = 3;
    localparam int ST_XSIGN   = 4;
    localparam int ST_YSIGN   = 5;
    localparam int ST_XOVF    = 6;
    localparam int ST_YOVF    = 7;

    // start + 8 data + parity + stop
    localparam int FRAME_LEN = 11;

    // An overflowed axis is clamped toward its sign: positive -> 0xFF, negative -> 0x00.
    function automatic logic [7:0] sat_axis(input logic [7:0] raw, input logic ovf,
                                            input logic sign, input logic en);
        if (en && ovf)
            return sign ? 8'h00 : 8'hFF;
        return raw;
    endfunction

endpackage

// File: rtl/ps2_mouse_packetizer_if.sv
// PS/2 line inputs and packed mouse-packet outputs of the packetizer.
// slave = packetizer side, master = bus/consumer side.
interface ps2_mouse_packetizer_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [24:0] ps2_mouse;
    logic        pkt_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  ps2_mouse,
        input  pkt_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output ps2_mouse,
        output pkt_err
    );
endinterface

// File: rtl/ps2_mouse_packetizer_rx_byte.sv
// PS/2 byte receiver: 2-FF sync, clock glitch filter, 11-bit frame FSM.
// byte_valid/byte_err lag the raw stop edge by FILT_LEN+3 cycles; receive-only, no backpressure.
module ps2_rx_byte
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int BIT_TIMEOUT = 4096
)(
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_err,
    output logic       timeout
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(BIT_TIMEOUT + 1);
    localparam logic [3:0] PAR_IDX  = 4'(FRAME_LEN - 3);
    localparam logic [3:0] STOP_IDX = 4'(FRAME_LEN - 2);

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    rx_state_t     state;
    rx_state_t     state_nxt;
    logic [3:0]    bitcnt;
    logic [TW-1:0] tmr;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          start;
    logic          take_bit;
    logic          frame_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // Level flips on the FILT_LEN-th consecutive sample that disagrees with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                fall     <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= RX_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (start) state_nxt = RX_SHIFT;
            RX_SHIFT: begin
                if (timeout)
                    state_nxt = RX_IDLE;
                else if (take_bit && bitcnt == STOP_IDX)
                    state_nxt = RX_IDLE;
            end
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // A stalled frame beats a coincident edge: the edge is dropped.
    always_comb begin
        timeout  = (state == RX_SHIFT) && (tmr == TW'(BIT_TIMEOUT));
        start    = (state == RX_IDLE) && fall && !data_sync[1];
        take_bit = (state == RX_SHIFT) && fall && !timeout;
        frame_ok = (^{shreg, par_bit}) && data_sync[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bitcnt     <= '0;
            tmr        <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (start) begin
                bitcnt <= '0;
                tmr    <= '0;
            end else if (state == RX_SHIFT) begin
                if (timeout) begin
                    bitcnt <= '0;
                    tmr    <= '0;
                end else if (take_bit) begin
                    tmr <= '0;
                    if (bitcnt < PAR_IDX) begin
                        shreg  <= {data_sync[1], shreg[7:1]};
                        bitcnt <= bitcnt + 1'b1;
                    end else if (bitcnt == PAR_IDX) begin
                        par_bit <= data_sync[1];
                        bitcnt  <= bitcnt + 1'b1;
                    end else begin
                        byte_valid <= frame_ok;
                        byte_err   <= !frame_ok;
                        bitcnt     <= '0;
                    end
                end else begin
                    tmr <= tmr + 1'b1;
                end
            end
        end
    end

    assign byte_data = shreg;

endmodule

// File: rtl/ps2_mouse_packetizer.sv
// 3-byte PS/2 stream packet assembler with overflow saturation, committing {strobe, dy, dx, status}.
// Strobe lags the raw stop edge of byte 3 by FILT_LEN+4 cycles; receive-only, no backpressure.
module ps2_mouse_packetizer
    import ps2_pkg::*;
#(
    parameter int FILT_LEN    = 8,
    parameter int BIT_TIMEOUT = 4096,
    parameter int PKT_TIMEOUT = 65536,
    parameter int SAT_OVF     = 1
)(
    input  logic                 clk,
    input  logic                 reset,
    ps2_mouse_packetizer_if.slave bus
);

    localparam int GW = $clog2(PKT_TIMEOUT + 1);

    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_err;
    logic          rx_timeout;

    asm_state_t    state;
    asm_state_t    state_nxt;
    logic [GW-1:0] gap;
    logic [7:0]    status;
    logic [7:0]    dx_raw;
    logic [23:0]   mouse_dat;
    logic          strobe;
    logic          pkt_err_q;

    logic          pkt_to;
    logic          accept;
    logic          hdr_bad;
    logic          load_status;
    logic          load_dx;
    logic          commit;
    logic          err_now;

    ps2_rx_byte #(
        .FILT_LEN    (FILT_LEN),
        .BIT_TIMEOUT (BIT_TIMEOUT)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_err   (byte_err),
        .timeout    (rx_timeout)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ASM_B0;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (pkt_to || byte_err || rx_timeout) begin
            state_nxt = ASM_B0;
        end else if (accept) begin
            case (state)
                ASM_B0:  if (byte_data[ST_ALWAYS1]) state_nxt = ASM_B1;
                ASM_B1:  state_nxt = ASM_B2;
                ASM_B2:  state_nxt = ASM_B0;
                default: state_nxt = ASM_B0;
            endcase
        end
    end

    // All error sources merge into one registered pulse, so coincident faults report once.
    always_comb begin
        pkt_to      = (state != ASM_B0) && (gap == GW'(PKT_TIMEOUT));
        accept      = byte_valid && !pkt_to;
        hdr_bad     = accept && (state == ASM_B0) && !byte_data[ST_ALWAYS1];
        load_status = accept && (state == ASM_B0) && byte_data[ST_ALWAYS1];
        load_dx     = accept && (state == ASM_B1);
        commit      = accept && (state == ASM_B2);
        err_now     = pkt_to || byte_err || rx_timeout || hdr_bad;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gap       <= '0;
            status    <= '0;
            dx_raw    <= '0;
            mouse_dat <= '0;
            strobe    <= 1'b0;
            pkt_err_q <= 1'b0;
        end else begin
            pkt_err_q <= err_now;
            strobe    <= commit;
            if (state == ASM_B0 || accept || pkt_to)
                gap <= '0;
            else if (gap != {GW{1'b1}})
                gap <= gap + 1'b1;
            if (load_status)
                status <= byte_data;
            if (load_dx)
                dx_raw <= byte_data;
            if (commit)
                mouse_dat <= {sat_axis(byte_data, status[ST_YOVF], status[ST_YSIGN], SAT_OVF != 0),
                              sat_axis(dx_raw, status[ST_XOVF], status[ST_XSIGN], SAT_OVF != 0),
                              status};
        end
    end

    assign bus.ps2_mouse = {strobe, mouse_dat};
    assign bus.pkt_err   = pkt_err_q;

endmodule

// File: tb/tb_ps2_mouse_packetizer.sv
// Directed bench for ps2_mouse_packetizer: one saturating and one raw-passthrough instance share the PS/2 lines.
// PS/2 clock is scaled to 40 system cycles per bit (12 kHz against a 480 kHz clk).
module tb_ps2_mouse_packetizer;
    import ps2_pkg::*;

    localparam int F  = 8;
    localparam int BT = 100;
    localparam int PT = 1000;
    localparam int H  = 20;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_mouse_packetizer_if bus0();
    ps2_mouse_packetizer_if bus1();

    ps2_mouse_packetizer #(.FILT_LEN(F), .BIT_TIMEOUT(BT), .PKT_TIMEOUT(PT), .SAT_OVF(1)) dut (
        .clk(clk), .reset(reset), .bus(bus0));
    ps2_mouse_packetizer #(.FILT_LEN(F), .BIT_TIMEOUT(BT), .PKT_TIMEOUT(PT), .SAT_OVF(0)) dut_raw (
        .clk(clk), .reset(reset), .bus(bus1));

    int n_checks = 0;
    int n_fail   = 0;
    int n_strobe = 0;
    int n_err    = 0;
    int n_b2b    = 0;
    int strobe_cyc = 0;
    int err_cyc    = 0;
    int stop_cyc   = 0;
    int fall_cyc   = 0;
    logic [23:0] strobe_dat = '0;
    logic        prev_strobe = 1'b0;

    always @(negedge clk) begin
        if (bus0.ps2_mouse[24] === 1'b1) begin
            n_strobe++;
            strobe_cyc = cyc;
            strobe_dat = bus0.ps2_mouse[23:0];
            if (prev_strobe) n_b2b++;
        end
        prev_strobe = (bus0.ps2_mouse[24] === 1'b1);
        if (bus0.pkt_err === 1'b1) begin
            n_err++;
            err_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_lines(input logic c, input logic d);
        bus0.ps2_clk  = c;
        bus0.ps2_data = d;
        bus1.ps2_clk  = c;
        bus1.ps2_data = d;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            set_lines(1'b1, fr[i]);
            tick(H);
            set_lines(1'b0, fr[i]);
            fall_cyc = cyc;
            if (i == FRAME_LEN - 1) stop_cyc = cyc;
            tick(H);
        end
        set_lines(1'b1, 1'b1);
        tick(2 * H);
    endtask

    task automatic pkt_commit(input string tag, input logic [7:0] s, input logic [7:0] x,
                              input logic [7:0] y, input logic [23:0] exp);
        int ns, ne;
        ns = n_strobe;
        ne = n_err;
        send_frame(s, 1'b0, FRAME_LEN);
        send_frame(x, 1'b0, FRAME_LEN);
        send_frame(y, 1'b0, FRAME_LEN);
        chk({tag, ".n_strobe"}, n_strobe - ns, 1);
        chk({tag, ".data"}, 32'(strobe_dat), 32'(exp));
        chk({tag, ".latency"}, strobe_cyc - stop_cyc, F + 4);
        chk({tag, ".no_err"}, n_err - ne, 0);
        chk({tag, ".held"}, 32'(bus0.ps2_mouse), {7'd0, 1'b0, exp});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d limit=100000", cyc);
        $fatal(1);
    end

    initial begin
        int ne, ns;
        set_lines(1'b1, 1'b1);
        reset = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(2);
        chk("reset.mouse", 32'(bus0.ps2_mouse), 0);
        chk("reset.err", 32'(bus0.pkt_err), 0);

        pkt_commit("clean", 8'h09, 8'h05, 8'hFD, 24'hFD0509);

        ne = n_err;
        send_frame(8'h05, 1'b0, FRAME_LEN);
        chk("resync.err", n_err - ne, 1);
        pkt_commit("resync", 8'h08, 8'h01, 8'h02, 24'h020108);

        ne = n_err;
        ns = n_strobe;
        send_frame(8'h09, 1'b0, FRAME_LEN);
        send_frame(8'h05, 1'b1, FRAME_LEN);
        chk("parity.err", n_err - ne, 1);
        chk("parity.no_commit", n_strobe - ns, 0);
        pkt_commit("parity_recover", 8'h09, 8'h07, 8'h03, 24'h030709);

        ne = n_err;
        send_frame(8'h00, 1'b0, 4);
        tick(BT + 20);
        chk("bit_to.err", n_err - ne, 1);
        chk("bit_to.when", err_cyc - fall_cyc, F + BT + 4);

        ne = n_err;
        ns = n_strobe;
        send_frame(8'h09, 1'b0, FRAME_LEN);
        tick(PT + 20);
        chk("pkt_to.err", n_err - ne, 1);
        chk("pkt_to.when", err_cyc - stop_cyc, F + PT + 5);
        send_frame(8'h01, 1'b0, FRAME_LEN);
        send_frame(8'h02, 1'b0, FRAME_LEN);
        chk("pkt_to.rejects", n_err - ne, 3);
        chk("pkt_to.no_commit", n_strobe - ns, 0);

        pkt_commit("sat_xneg", 8'h58, 8'h12, 8'h34, 24'h340058);
        chk("raw_xneg", 32'(bus1.ps2_mouse[23:0]), 32'h341258);
        pkt_commit("sat_xpos", 8'h48, 8'h12, 8'h34, 24'h34FF48);
        chk("raw_xpos", 32'(bus1.ps2_mouse[23:0]), 32'h341248);
        pkt_commit("sat_ypos", 8'h88, 8'h10, 8'h20, 24'hFF1088);
        chk("raw_ypos", 32'(bus1.ps2_mouse[23:0]), 32'h201088);
        pkt_commit("sat_yneg", 8'hA8, 8'h10, 8'h20, 24'h0010A8);
        chk("raw_yneg", 32'(bus1.ps2_mouse[23:0]), 32'h2010A8);

        ne = n_err;
        set_lines(1'b0, 1'b0);
        tick(F - 1);
        set_lines(1'b1, 1'b1);
        tick(BT + 50);
        chk("glitch.no_err", n_err - ne, 0);
        pkt_commit("glitch", 8'h09, 8'h11, 8'h22, 24'h221109);

        send_frame(8'h09, 1'b0, FRAME_LEN);
        send_frame(8'h33, 1'b0, 5);
        ne = n_err;
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        chk("rst_mid.mouse", 32'(bus0.ps2_mouse), 0);
        chk("rst_mid.err", 32'(bus0.pkt_err), 0);
        tick(PT + BT + 50);
        chk("rst_mid.silent", n_err - ne, 0);
        pkt_commit("post_reset", 8'h09, 8'h05, 8'hFD, 24'hFD0509);

        chk("strobe.b2b", n_b2b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
